// File: rtl/adc_capture_pkg.sv
// Shared definitions for the ADC result capture block: capture FSM states and
// the width of the ADC configuration words.
package adc_capture_pkg;

  localparam int CFG_W = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/adc_capture_fifo.sv
// Synchronous first-word-fall-through FIFO for captured ADC results.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
// A pop on an empty FIFO is ignored. data reads as zero while empty.
module adc_capture_fifo #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign data    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  // Pointer update; occupancy follows one cycle after push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/adc_result_capture.sv
// Host-side capture of SAR-ADC results. Drives the ADC reset and config words,
// synchronises the ADC's conversion-finished strobe into clk, samples the result
// on its rising edge and buffers it in a FWFT FIFO behind a valid/ready stream.
// Supports continuous capture (burst_len 0) and fixed-length bursts.
// Optional feature macro: ADC_CAPTURE_STATS_EN adds saturating sample/drop counters.
module adc_result_capture
  import adc_capture_pkg::*;
#(
  parameter int DATA_W        = 10,
  parameter int FIFO_DEPTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_in,
  input  logic                          stop_in,
  input  logic [CNT_W-1:0]              burst_len_in,
  input  logic [CFG_W-1:0]              cfg_1_in,
  input  logic [CFG_W-1:0]              cfg_2_in,
  output logic                          adc_rst_n_out,
  output logic [CFG_W-1:0]              adc_config_1_out,
  output logic [CFG_W-1:0]              adc_config_2_out,
  input  logic [DATA_W-1:0]             adc_result_in,
  input  logic                          adc_conv_finished_in,
  output logic [DATA_W-1:0]             data_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          busy_out,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   level_out
`ifdef ADC_CAPTURE_STATS_EN
  ,
  output logic [CNT_W-1:0]              sample_cnt_out,
  output logic [CNT_W-1:0]              drop_cnt_out
`endif
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t                  state;
  logic [SET_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        burst_cnt;
  logic [CNT_W-1:0]        burst_len_q;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_last;
  logic                    strobe_rise;
  logic                    capture;
  logic                    start_ok;
  logic                    last_of_burst;

  logic                    cap_vld;
  logic [DATA_W-1:0]       result_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    drop;

  // A start is honoured only from IDLE and only when no stop arrives with it.
  assign start_ok      = (state == IDLE) && start_in && !stop_in;
  assign strobe_rise   = sync_q[SYNC_STAGES-1] & ~sync_last;
  assign capture       = strobe_rise && (state == RUN);
  assign last_of_burst = (burst_len_q != '0) && (burst_cnt + CNT_W'(1) == burst_len_q);
  assign busy_out      = (state != IDLE);
  assign valid_out     = ~fifo_empty;
  // Full FIFO implies valid_out, so ready_in alone tells whether a slot frees up.
  assign drop          = cap_vld & fifo_full & ~ready_in;

  // Strobe synchroniser plus one extra flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      sync_last <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], adc_conv_finished_in};
      sync_last <= sync_q[SYNC_STAGES-1];
    end
  end

  // Result sampling: the bus is stable by the time the synchronised edge arrives;
  // the registered sample is pushed into the FIFO on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_vld  <= 1'b0;
      result_q <= '0;
    end else begin
      cap_vld <= capture;
      if (capture) result_q <= adc_result_in;
    end
  end

  // Capture FSM with registered ADC reset, config words and burst counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      adc_rst_n_out    <= 1'b0;
      adc_config_1_out <= '0;
      adc_config_2_out <= '0;
      settle_cnt       <= '0;
      burst_cnt        <= '0;
      burst_len_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state            <= SETTLE;
            adc_rst_n_out    <= 1'b1;
            adc_config_1_out <= cfg_1_in;
            adc_config_2_out <= cfg_2_in;
            settle_cnt       <= '0;
            burst_cnt        <= '0;
            burst_len_q      <= burst_len_in;
          end
        end
        SETTLE: begin
          if (stop_in) begin
            state         <= IDLE;
            adc_rst_n_out <= 1'b0;
          end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          // A capture coinciding with stop is still counted and buffered.
          if (capture) burst_cnt <= burst_cnt + CNT_W'(1);
          if (stop_in || (capture && last_of_burst)) begin
            state         <= IDLE;
            adc_rst_n_out <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          adc_rst_n_out <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: set when a sample is lost, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow_out <= 1'b0;
    else if (drop)     overflow_out <= 1'b1;
    else if (start_ok) overflow_out <= 1'b0;
  end

`ifdef ADC_CAPTURE_STATS_EN
  // Saturating capture and drop counters, restarted with each run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_out <= '0;
      drop_cnt_out   <= '0;
    end else if (start_ok) begin
      sample_cnt_out <= '0;
      drop_cnt_out   <= '0;
    end else begin
      if (capture && (sample_cnt_out != '1)) sample_cnt_out <= sample_cnt_out + CNT_W'(1);
      if (drop && (drop_cnt_out != '1))      drop_cnt_out   <= drop_cnt_out + CNT_W'(1);
    end
  end
`endif

  adc_capture_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_vld),
    .push_data (result_q),
    .pop       (ready_in),
    .data      (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level_out)
  );

endmodule

// File: tb/tb_adc_result_capture.sv
// Randomised bench for adc_result_capture against a queue-based model of the
// capture stream: samples taken while running, FIFO ordering, drops and bursts.
module tb_adc_result_capture;

  localparam int DEPTH  = 8;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b0;
  logic        stop_in = 1'b0;
  logic [15:0] burst_len_in = '0;
  logic [9:0]  cfg_1_in = '0;
  logic [9:0]  cfg_2_in = '0;
  logic        adc_rst_n_out;
  logic [9:0]  adc_config_1_out;
  logic [9:0]  adc_config_2_out;
  logic [9:0]  adc_result_in = '0;
  logic        adc_conv_finished_in = 1'b0;
  logic [9:0]  data_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        busy_out;
  logic        overflow_out;
  logic [3:0]  level_out;
`ifdef ADC_CAPTURE_STATS_EN
  logic [15:0] sample_cnt_out;
  logic [15:0] drop_cnt_out;
`endif

  adc_result_capture dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_in             (start_in),
    .stop_in              (stop_in),
    .burst_len_in         (burst_len_in),
    .cfg_1_in             (cfg_1_in),
    .cfg_2_in             (cfg_2_in),
    .adc_rst_n_out        (adc_rst_n_out),
    .adc_config_1_out     (adc_config_1_out),
    .adc_config_2_out     (adc_config_2_out),
    .adc_result_in        (adc_result_in),
    .adc_conv_finished_in (adc_conv_finished_in),
    .data_out             (data_out),
    .valid_out            (valid_out),
    .ready_in             (ready_in),
    .busy_out             (busy_out),
    .overflow_out         (overflow_out),
    .level_out            (level_out)
`ifdef ADC_CAPTURE_STATS_EN
    ,
    .sample_cnt_out       (sample_cnt_out),
    .drop_cnt_out         (drop_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [9:0]  q[$];
  bit          m_run = 0;
  int          m_cnt = 0;
  int          m_blen = 0;
  bit          m_ovf = 0;
  int          m_samp = 0;
  int          m_drop = 0;
  bit          rnd_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_start(input logic [15:0] bl, input logic [9:0] c1, input logic [9:0] c2,
                          input bit wait_settle);
    burst_len_in = bl; cfg_1_in = c1; cfg_2_in = c2;
    start_in = 1'b1; cyc(1); start_in = 1'b0;
    m_blen = int'(bl); m_cnt = 0; m_ovf = 0; m_samp = 0; m_drop = 0; m_run = 0;
    if (wait_settle) begin cyc(SETTLE + 1); m_run = 1; end
  endtask

  task automatic do_stop();
    stop_in = 1'b1; cyc(1); stop_in = 1'b0; m_run = 0;
  endtask

  // One ADC conversion: strobe high for 4 cycles, 6-cycle period. With pop_at_push
  // the consumer is ready exactly in the cycle the captured sample reaches the FIFO.
  task automatic strobe(input logic [9:0] r, input bit pop_at_push);
    adc_result_in = r; adc_conv_finished_in = 1'b1;
    if (m_run) begin
      m_cnt++; m_samp++;
      if (q.size() >= DEPTH && !pop_at_push) begin m_ovf = 1; m_drop++; end
      else q.push_back(r);
      if (m_blen != 0 && m_cnt == m_blen) m_run = 0;
    end
    cyc(3);
    if (pop_at_push) ready_in = 1'b1;
    cyc(1);
    if (pop_at_push) ready_in = 1'b0;
    adc_conv_finished_in = 1'b0;
    cyc(2);
  endtask

  task automatic drain();
    ready_in = 1'b1; cyc(DEPTH + 4); ready_in = 1'b0; cyc(1);
    chk("drain_level", 32'(level_out), 32'(q.size()));
    chk("drain_valid", 32'(valid_out), 32'd0);
  endtask

  // scoreboard: every accepted word must match the model's oldest entry
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      if (q.size() == 0) chk("pop_extra", 32'(data_out), 32'h7fffffff);
      else               chk("pop_data", 32'(data_out), 32'(q.pop_front()));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) ready_in = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [9:0] c1, c2;
    logic [9:0] dir_res [3];
    dir_res[0] = 10'h001; dir_res[1] = 10'h3FF; dir_res[2] = 10'h155;

    // 1: reset
    cyc(3); rst = 1'b0; cyc(1);
    chk("rst_adc_rst_n", 32'(adc_rst_n_out), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_cfg1", 32'(adc_config_1_out), 32'd0);
    chk("rst_cfg2", 32'(adc_config_2_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);

    // start and stop together: stays idle
    start_in = 1'b1; stop_in = 1'b1; cyc(1); start_in = 1'b0; stop_in = 1'b0; cyc(1);
    chk("startstop_busy", 32'(busy_out), 32'd0);
    chk("startstop_rstn", 32'(adc_rst_n_out), 32'd0);

    // 2: burst of 3
    do_start(16'd3, 10'h2A5, 10'h0F0, 1'b1);
    chk("t2_cfg1", 32'(adc_config_1_out), 32'h2A5);
    chk("t2_cfg2", 32'(adc_config_2_out), 32'h0F0);
    chk("t2_rstn", 32'(adc_rst_n_out), 32'd1);
    chk("t2_busy", 32'(busy_out), 32'd1);
    for (int i = 0; i < 3; i++) strobe(dir_res[i], 1'b0);
    chk("t2_busy_end", 32'(busy_out), 32'd0);
    chk("t2_rstn_end", 32'(adc_rst_n_out), 32'd0);
    chk("t2_level", 32'(level_out), 32'(q.size()));
    chk("t2_head", 32'(data_out), 32'h001);
    drain();

    // 3: strobe while settling is discarded
    do_start(16'd0, 10'h011, 10'h022, 1'b0);
    strobe(10'h2C3, 1'b0);
    do_stop();
    cyc(2);
    chk("t3_level", 32'(level_out), 32'd0);
    chk("t3_valid", 32'(valid_out), 32'd0);

    // 4: continuous, consumer stalled, 10 samples into 8 entries
    do_start(16'd0, 10'h100, 10'h200, 1'b1);
    for (int i = 0; i < 10; i++) strobe(10'($urandom), 1'b0);
    chk("t4_level", 32'(level_out), 32'(q.size()));
    chk("t4_ovf", 32'(overflow_out), 32'(m_ovf));
`ifdef ADC_CAPTURE_STATS_EN
    chk("t4_drops", 32'(drop_cnt_out), 32'(m_drop));
    chk("t4_samples", 32'(sample_cnt_out), 32'(m_samp));
`endif
    do_stop();
    chk("t4_stop_level", 32'(level_out), 32'd8);

    // 5: full FIFO, pop coincides with push
    do_start(16'd0, 10'h155, 10'h2AA, 1'b1);
    chk("t5_ovf_cleared", 32'(overflow_out), 32'd0);
    strobe(10'($urandom), 1'b1);
    chk("t5_level", 32'(level_out), 32'(q.size()));
    chk("t5_ovf", 32'(overflow_out), 32'(m_ovf));
`ifdef ADC_CAPTURE_STATS_EN
    chk("t5_drops", 32'(drop_cnt_out), 32'(m_drop));
    chk("t5_samples", 32'(sample_cnt_out), 32'(m_samp));
`endif
    do_stop();
    drain();

    // random bursts with random backpressure
    for (int it = 0; it < 6; it++) begin
      int bl;
      bl = $urandom_range(1, 5);
      c1 = 10'($urandom); c2 = 10'($urandom);
      do_start(16'(bl), c1, c2, 1'b1);
      chk("rnd_cfg1", 32'(adc_config_1_out), 32'(c1));
      chk("rnd_cfg2", 32'(adc_config_2_out), 32'(c2));
      rnd_rdy = 1;
      for (int s = 0; s <= bl; s++) strobe(10'($urandom), 1'b0);
      chk("rnd_busy_end", 32'(busy_out), 32'd0);
      rnd_rdy = 0;
      cyc(1);
      drain();
    end

    // 6: async reset in the middle of a run
    do_start(16'd0, 10'h3C3, 10'h0C3, 1'b1);
    for (int i = 0; i < 4; i++) strobe(10'($urandom), 1'b0);
    chk("t6_level_pre", 32'(level_out), 32'd4);
    rst = 1'b1; #1;
    chk("t6_rstn", 32'(adc_rst_n_out), 32'd0);
    chk("t6_level", 32'(level_out), 32'd0);
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_busy", 32'(busy_out), 32'd0);
    chk("t6_cfg1", 32'(adc_config_1_out), 32'd0);
    q.delete(); m_run = 0;
    cyc(2); rst = 1'b0; cyc(2);
    chk("t6_idle_after", 32'(busy_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
